// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU/debug request ports and RAM port bundle for mem_arbiter
// Modport slave is the arbiter's view; master is the requester/RAM-side view.
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output gnt_a, rvalid_a, rdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_b, rvalid_b, rdata_b,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  gnt_a, rvalid_a, rdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto a single-port synchronous RAM
// Optional MEM_ARB_LOCK_EN adds lock_b, letting port B keep winning ties up to LOCK_MAX grants.
module mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MEM_ARB_LOCK_EN
  input  logic lock_b,
`endif
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state;
  logic          last_b;
  logic          any_req;
  logic          pick_b;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;

`ifdef MEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt;
  logic          lock_win;
`endif

  always_comb begin
    any_req = bus.req_a | bus.req_b;
`ifdef MEM_ARB_LOCK_EN
    // B keeps a tie only while it was granted last and the lock budget is not spent
    lock_win = bus.req_a && bus.req_b && last_b && lock_b && (lock_cnt < CW'(LOCK_MAX));
    pick_b   = bus.req_b && (!bus.req_a || !last_b || lock_win);
`else
    pick_b   = bus.req_b && (!bus.req_a || !last_b);
`endif
    win_addr  = pick_b ? bus.addr_b  : bus.addr_a;
    win_wdata = pick_b ? bus.wdata_b : bus.wdata_a;
    win_we    = pick_b ? bus.we_b    : bus.we_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      last_b        <= 1'b1;
      bus.gnt_a     <= 1'b0;
      bus.gnt_b     <= 1'b0;
      bus.rvalid_a  <= 1'b0;
      bus.rvalid_b  <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_ACCESS: begin
          bus.gnt_a    <= 1'b0;
          bus.gnt_b    <= 1'b0;
          bus.mem_en   <= 1'b0;
          bus.mem_we   <= 1'b0;
          bus.rvalid_a <= bus.gnt_a & ~bus.mem_we;
          bus.rvalid_b <= bus.gnt_b & ~bus.mem_we;
          state        <= bus.mem_we ? S_IDLE : S_RESP;
        end
        default: begin
          // RESP overlaps the next arbitration, so reads sustain one access per two cycles
          bus.rvalid_a <= 1'b0;
          bus.rvalid_b <= 1'b0;
          if (any_req) begin
            state         <= S_ACCESS;
            last_b        <= pick_b;
            bus.gnt_a     <= ~pick_b;
            bus.gnt_b     <= pick_b;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= win_we;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
          end else begin
            state         <= S_IDLE;
            bus.gnt_a     <= 1'b0;
            bus.gnt_b     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (!lock_b) begin
      lock_cnt <= '0;
    end else if (state != S_ACCESS && any_req) begin
      if (!pick_b)
        lock_cnt <= '0;
      else if (lock_win)
        lock_cnt <= lock_cnt + 1'b1;
    end
  end
`endif

  assign bus.rdata_a = bus.rvalid_a ? bus.mem_rdata : '0;
  assign bus.rdata_b = bus.rvalid_b ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural RAM
// Lock-mode sequence is compiled in only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MEM_ARB_LOCK_EN
  logic lock_b = 1'b0;
`endif
  int n_pass = 0;
  int n_total = 0;

  mem_arbiter_if #(.AW(10), .DW(8)) bus ();

  mem_arbiter #(.AW(10), .DW(8), .LOCK_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MEM_ARB_LOCK_EN
    .lock_b(lock_b),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic ra; logic wa; logic [9:0] aa; logic [7:0] da;
    logic rb; logic wb; logic [9:0] ab; logic [7:0] db;
    logic e_ga; logic e_gb; logic e_we; logic [9:0] e_addr; logic [7:0] e_wd;
    logic e_rva; logic e_rvb; logic [7:0] e_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1, 1, 10'h155, 8'hA5, 0, 0, 10'h000, 8'h00, 1, 0, 1, 10'h155, 8'hA5, 0, 0, 8'h00};
    vecs[1] = '{0, 0, 10'h000, 8'h00, 1, 1, 10'h3FF, 8'h5A, 0, 1, 1, 10'h3FF, 8'h5A, 0, 0, 8'h00};
    vecs[2] = '{0, 0, 10'h000, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 1, 0, 10'h3FF, 8'h00, 0, 1, 8'h5A};
    vecs[3] = '{1, 0, 10'h155, 8'h33, 1, 0, 10'h001, 8'h44, 1, 0, 0, 10'h155, 8'h33, 1, 0, 8'hA5};
    vecs[4] = '{1, 1, 10'h002, 8'h11, 1, 1, 10'h200, 8'h22, 0, 1, 1, 10'h200, 8'h22, 0, 0, 8'h00};
    vecs[5] = '{1, 0, 10'h200, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 10'h200, 8'h00, 1, 0, 8'h22};
    vecs[6] = '{1, 0, 10'h000, 8'h77, 1, 0, 10'h200, 8'h66, 0, 1, 0, 10'h200, 8'h66, 0, 1, 8'h22};
    vecs[7] = '{1, 1, 10'h000, 8'hFF, 0, 0, 10'h000, 8'h00, 1, 0, 1, 10'h000, 8'hFF, 0, 0, 8'h00};
    vecs[8] = '{0, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00, 0, 1, 0, 10'h000, 8'h00, 0, 1, 8'hFF};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;

    #1;
    chk("rst gnt_a", bus.gnt_a, 0);
    chk("rst gnt_b", bus.gnt_b, 0);
    chk("rst rvalid_a", bus.rvalid_a, 0);
    chk("rst rvalid_b", bus.rvalid_b, 0);
    chk("rst mem_en", bus.mem_en, 0);
    chk("rst mem_we", bus.mem_we, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    tick(); tick();
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      bus.req_a = vecs[i].ra; bus.we_a = vecs[i].wa; bus.addr_a = vecs[i].aa; bus.wdata_a = vecs[i].da;
      bus.req_b = vecs[i].rb; bus.we_b = vecs[i].wb; bus.addr_b = vecs[i].ab; bus.wdata_b = vecs[i].db;
      tick();
      chk($sformatf("v%0d gnt_a", i), bus.gnt_a, vecs[i].e_ga);
      chk($sformatf("v%0d gnt_b", i), bus.gnt_b, vecs[i].e_gb);
      chk($sformatf("v%0d mem_en", i), bus.mem_en, 1);
      chk($sformatf("v%0d mem_we", i), bus.mem_we, vecs[i].e_we);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_wd);
      bus.req_a = 0; bus.req_b = 0;
      tick();
      chk($sformatf("v%0d gnt_a drop", i), bus.gnt_a, 0);
      chk($sformatf("v%0d gnt_b drop", i), bus.gnt_b, 0);
      chk($sformatf("v%0d mem_en drop", i), bus.mem_en, 0);
      chk($sformatf("v%0d mem_we drop", i), bus.mem_we, 0);
      chk($sformatf("v%0d mem_addr hold", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d rvalid_a", i), bus.rvalid_a, vecs[i].e_rva);
      chk($sformatf("v%0d rvalid_b", i), bus.rvalid_b, vecs[i].e_rvb);
      chk($sformatf("v%0d rdata_a", i), bus.rdata_a, vecs[i].e_rva ? vecs[i].e_rd : 8'h00);
      chk($sformatf("v%0d rdata_b", i), bus.rdata_b, vecs[i].e_rvb ? vecs[i].e_rd : 8'h00);
      tick();
    end

    // both ports reading continuously: A first, then strict alternation every two cycles
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 10'h155;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 10'h3FF;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("alt%0d gnt_a", c), bus.gnt_a, (c % 4) == 0);
      chk($sformatf("alt%0d gnt_b", c), bus.gnt_b, (c % 4) == 2);
      chk($sformatf("alt%0d rvalid_a", c), bus.rvalid_a, (c % 4) == 1);
      chk($sformatf("alt%0d rvalid_b", c), bus.rvalid_b, (c % 4) == 3);
      chk($sformatf("alt%0d rdata_a", c), bus.rdata_a, ((c % 4) == 1) ? 8'hA5 : 8'h00);
      chk($sformatf("alt%0d rdata_b", c), bus.rdata_b, ((c % 4) == 3) ? 8'h5A : 8'h00);
    end
    bus.req_a = 0; bus.req_b = 0;
    tick();

    // reset pulse in the middle of a read ACCESS
    bus.req_b = 1;
    tick();
    chk("rstmid gnt_b before", bus.gnt_b, 1);
    chk("rstmid mem_en before", bus.mem_en, 1);
    bus.req_b = 0;
    #1 rst_n = 0;
    #1;
    chk("rstmid gnt_b", bus.gnt_b, 0);
    chk("rstmid mem_en", bus.mem_en, 0);
    chk("rstmid mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rstmid rvalid_b %0d", c), bus.rvalid_b, 0);
      chk($sformatf("rstmid rvalid_a %0d", c), bus.rvalid_a, 0);
    end
    bus.req_a = 1; bus.req_b = 1;
    tick();
    chk("post-rst tie gnt_a", bus.gnt_a, 1);
    chk("post-rst tie gnt_b", bus.gnt_b, 0);
    bus.req_a = 0; bus.req_b = 0;
    tick(); tick();

`ifdef MEM_ARB_LOCK_EN
    lock_b = 1;
    bus.req_b = 1;
    tick();
    chk("lock first gnt_b", bus.gnt_b, 1);
    bus.req_b = 0;
    tick();
    bus.req_a = 1; bus.req_b = 1;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk($sformatf("lock g%0d gnt_b", g), bus.gnt_b, g < 8);
      chk($sformatf("lock g%0d gnt_a", g), bus.gnt_a, g == 8);
      tick();
    end
    lock_b = 0;
    for (int g = 0; g < 2; g++) begin
      tick();
      chk($sformatf("unlock g%0d gnt_b", g), bus.gnt_b, g == 0);
      chk($sformatf("unlock g%0d gnt_a", g), bus.gnt_a, g == 1);
      tick();
    end
    bus.req_a = 0; bus.req_b = 0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, RAM address width (matches {r1[1:0], r2} addressing).
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter LOCK_MAX, default 8, max consecutive locked port-B grants.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_a, we_a  input  1 each  CPU port (A): access request, write enable.
REQ-007 addr_a  input  AW; wdata_a  input  DW  CPU port address / write data.
REQ-008 gnt_a, rvalid_a  output  1 each; rdata_a  output  DW  CPU port grant, read-valid, read data.
REQ-009 req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same widths/directions as port A, debug/loader port (B).
REQ-010 mem_en, mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW  RAM port; all registered.
REQ-011 mem_rdata  input  DW  RAM read data, valid exactly one cycle after the mem_en cycle.
REQ-012 lock_b  input  1  present only when MEM_ARB_LOCK_EN is defined.

Function
REQ-013 FSM states: IDLE, ACCESS, RESP; encoding free.
REQ-014 Requests sampled only in IDLE and RESP; ignored in ACCESS.
REQ-015 IDLE/RESP with any req high: next state ACCESS; winner's addr/we/wdata registered onto mem_*; else IDLE.
REQ-016 In ACCESS: mem_en=1, gnt of winner=1, other gnt=0; gnt lasts exactly one cycle.
REQ-017 ACCESS with mem_we=1: next IDLE; with mem_we=0: next RESP.
REQ-018 In RESP: rvalid of the port granted in the preceding ACCESS = 1 for one cycle; its rdata = mem_rdata.
REQ-019 rdata_x = 0 whenever rvalid_x = 0; rvalid never on the non-granted port.
REQ-020 Arbitration round-robin: single request wins; both requesting -> port not granted last; last-grant flag updates on every ACCESS entry.
REQ-021 Requester holds req/addr/we/wdata stable until its gnt; req still high in the cycle after gnt is a new access.
REQ-022 Throughput: write 1 access / 2 cycles; read 1 access / 2 cycles (RESP overlaps next arbitration); read latency req-sampled to rvalid = 2 cycles.
REQ-023 mem_* outside ACCESS: mem_en=0, mem_we=0, mem_addr/mem_wdata hold last value.
REQ-024 Address and data passed unmodified, no wrap or truncation; AW bits exactly.

Reset
REQ-025 rst_n low: immediately (asynchronously) state=IDLE, all gnt/rvalid/rdata/mem_en/mem_we=0, mem_addr=0, mem_wdata=0, last-grant=B (A wins first tie), lock counter=0.
REQ-026 Reset during ACCESS or RESP aborts the access; no rvalid after release.
REQ-027 First arbitration on first rising edge with rst_n high.

Configuration
REQ-028 Macro MEM_ARB_LOCK_EN: defined -> lock_b port exists; B granted last and lock_b=1 -> B wins ties for up to LOCK_MAX consecutive B grants, then A gets next tie; counter clears on any A grant or lock_b=0.
REQ-029 MEM_ARB_LOCK_EN undefined: lock_b port and counter absent; pure round-robin per REQ-020.

Verification
REQ-030 Reset release, req_a=1 we_a=1 addr_a=0x155 wdata_a=0xA5 -> next cycle mem_en=1 mem_we=1 mem_addr=0x155 mem_wdata=0xA5 gnt_a=1; then IDLE.
REQ-031 req_b read addr_b=0x3FF, mem_rdata=0x5A in cycle after ACCESS -> rvalid_b=1 rdata_b=0x5A, rvalid_a=0, rdata_a=0.
REQ-032 req_a and req_b held high continuously (reads) -> gnts alternate A,B,A,B starting with A; one grant every 2 cycles.
REQ-033 rst_n pulsed low mid-ACCESS of read -> mem_en, gnt drop same cycle; no rvalid follows; next tie grants A.
REQ-034 MEM_ARB_LOCK_EN, lock_b=1, both ports requesting after a B grant -> 8 consecutive B grants then gnt_a; lock_b=0 -> alternation resumes.
